// File: rtl/haar_cascade_param_loader.sv
// Haar cascade parameter loader: ROM -> per-stage buffers with checksum.
// Ports: clk/reset, load_start, rom_addr/rom_q, busy/done, flags, read port.
module haar_cascade_param_loader #(
  parameter int unsigned NUM_STAGES = 3,
  parameter int unsigned NUM_CLASSIFIERS = 10,
  parameter int unsigned NUM_PARAM_PER_CLASSIFIER = 19,
  parameter int unsigned NUM_STAGE_THRESHOLD = 3,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned ROM_LATENCY = 1,
  localparam int unsigned SW =
    NUM_CLASSIFIERS * NUM_PARAM_PER_CLASSIFIER
    + NUM_STAGE_THRESHOLD,
  localparam int unsigned SSW =
    (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1,
  localparam int unsigned WW =
    (SW > 1) ? $clog2(SW) : 1
) (
  input  logic                  clk_fpga,
  input  logic                  reset_fpga,
  input  logic                  load_start,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_q,
  output logic                  busy,
  output logic                  done,
  output logic [NUM_STAGES-1:0] stage_ready,
  output logic [NUM_STAGES-1:0] stage_error,
  output logic                  ready,
  input  logic [SSW-1:0]        rd_stage,
  input  logic [WW-1:0]         rd_word,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int unsigned N  = NUM_STAGES * (SW + 1);
  localparam int unsigned CW = $clog2(SW + 1);
  localparam int unsigned MD = NUM_STAGES * SW;
  localparam int unsigned MW = (MD > 1) ? $clog2(MD) : 1;
  localparam int unsigned L  = ROM_LATENCY;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic [SSW-1:0]        iss_stg_q, iss_stg_d;
  logic [CW-1:0]         iss_wrd_q, iss_wrd_d;
  logic [L-1:0]          pvld_q, pvld_d;
  logic [SSW-1:0]        pstg_q [L];
  logic [SSW-1:0]        pstg_d [L];
  logic [CW-1:0]         pwrd_q [L];
  logic [CW-1:0]         pwrd_d [L];
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [NUM_STAGES-1:0] sr_q, sr_d, se_q, se_d;
  logic                  done_q, done_d;

  logic                  mem_we;
  logic [MW-1:0]         mem_widx, rd_idx;
  logic [DATA_WIDTH-1:0] mem [MD];

  logic                  cap;
  logic [SSW-1:0]        cap_stg;
  logic [CW-1:0]         cap_wrd;

  assign cap     = pvld_q[L-1];
  assign cap_stg = pstg_q[L-1];
  assign cap_wrd = pwrd_q[L-1];

  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    iss_stg_d  = iss_stg_q;
    iss_wrd_d  = iss_wrd_q;
    acc_d      = acc_q;
    sr_d       = sr_q;
    se_d       = se_q;
    done_d     = 1'b0;
    mem_we     = 1'b0;
    mem_widx   = MW'(cap_stg) * MW'(SW) + MW'(cap_wrd);
    rd_idx     = MW'(rd_stage) * MW'(SW) + MW'(rd_word);

    // in-flight reads carry their stage/word tag
    pvld_d[0] = (state_q == S_ISSUE);
    pstg_d[0] = iss_stg_q;
    pwrd_d[0] = iss_wrd_q;
    for (int i = 1; i < L; i++) begin
      pvld_d[i] = pvld_q[i-1];
      pstg_d[i] = pstg_q[i-1];
      pwrd_d[i] = pwrd_q[i-1];
    end

    unique case (state_q)
      S_IDLE: begin
        if (load_start) begin
          state_d    = S_ISSUE;
          rom_addr_d = '0;
          iss_stg_d  = '0;
          iss_wrd_d  = '0;
          sr_d       = '0;
          se_d       = '0;
        end
      end
      S_ISSUE: begin
        if (iss_wrd_q == CW'(SW)) begin
          iss_wrd_d = '0;
          iss_stg_d = iss_stg_q + SSW'(1);
        end else begin
          iss_wrd_d = iss_wrd_q + CW'(1);
        end
        if (rom_addr_q == ADDR_WIDTH'(N - 1))
          state_d = S_DRAIN;
        else
          rom_addr_d = rom_addr_q + ADDR_WIDTH'(1);
      end
      S_DRAIN: begin
        // leave once the last in-flight word lands this edge
        if (pvld_d == '0) begin
          state_d    = S_IDLE;
          done_d     = 1'b1;
          rom_addr_d = '0;
        end
      end
      default: begin
        state_d    = S_IDLE;
        rom_addr_d = '0;
      end
    endcase

    if (cap) begin
      if (cap_wrd == CW'(SW)) begin
        if (acc_q == rom_q)
          sr_d = sr_q | (NUM_STAGES'(1) << cap_stg);
        else
          se_d = se_q | (NUM_STAGES'(1) << cap_stg);
      end else begin
        mem_we = 1'b1;
        acc_d  = (cap_wrd == '0 ? '0 : acc_q) + rom_q;
      end
    end

    rd_data_d = '0;
    if (32'(rd_stage) < NUM_STAGES && 32'(rd_word) < SW)
      rd_data_d = mem[rd_idx];
  end

  always_ff @(posedge clk_fpga or negedge reset_fpga) begin
    if (!reset_fpga) begin
      state_q    <= S_IDLE;
      rom_addr_q <= '0;
      iss_stg_q  <= '0;
      iss_wrd_q  <= '0;
      pvld_q     <= '0;
      for (int i = 0; i < L; i++) begin
        pstg_q[i] <= '0;
        pwrd_q[i] <= '0;
      end
      acc_q      <= '0;
      sr_q       <= '0;
      se_q       <= '0;
      done_q     <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      iss_stg_q  <= iss_stg_d;
      iss_wrd_q  <= iss_wrd_d;
      pvld_q     <= pvld_d;
      for (int i = 0; i < L; i++) begin
        pstg_q[i] <= pstg_d[i];
        pwrd_q[i] <= pwrd_d[i];
      end
      acc_q      <= acc_d;
      sr_q       <= sr_d;
      se_q       <= se_d;
      done_q     <= done_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // storage has no reset; contents are don't-care until reloaded
  always_ff @(posedge clk_fpga) begin
    if (mem_we)
      mem[mem_widx] <= rom_q;
  end

  assign rom_addr    = rom_addr_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign stage_ready = sr_q;
  assign stage_error = se_q;
  assign ready       = &sr_q;
  assign rd_data     = rd_data_q;

endmodule

// File: tb/tb_haar_cascade_param_loader.sv
// Bench for haar_cascade_param_loader: ROM model, timeline model,
// readback model; default instance plus 1-stage latency-3 instance.
module tb_haar_cascade_param_loader;

  localparam int NS  = 3;
  localparam int SW  = 193;
  localparam int L   = 1;
  localparam int N   = NS * (SW + 1);
  localparam int L2  = 3;
  localparam int N2  = SW + 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ls, ls2;
  logic [9:0] ra, ra2;
  logic [7:0] rq, rq2, r2a, r2b;
  logic       busy, done, ready;
  logic       busy2, done2, ready2;
  logic [2:0] sr, se;
  logic [0:0] sr2, se2;
  logic [1:0] rs;
  logic [0:0] rs2;
  logic [7:0] rw, rw2, rd, rd2;

  logic [7:0] rom  [1024];
  logic [7:0] rom2 [1024];
  logic [7:0] exp_mem [NS][SW];
  bit         good [NS];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rq  <= rom[ra];
    r2a <= rom2[ra2];
    r2b <= r2a;
    rq2 <= r2b;
  end

  haar_cascade_param_loader u_dut (
    .clk_fpga(clk), .reset_fpga(rst_n), .load_start(ls),
    .rom_addr(ra), .rom_q(rq), .busy(busy), .done(done),
    .stage_ready(sr), .stage_error(se), .ready(ready),
    .rd_stage(rs), .rd_word(rw), .rd_data(rd)
  );

  haar_cascade_param_loader #(
    .NUM_STAGES(1), .ROM_LATENCY(L2)
  ) u_dut2 (
    .clk_fpga(clk), .reset_fpga(rst_n), .load_start(ls2),
    .rom_addr(ra2), .rom_q(rq2), .busy(busy2), .done(done2),
    .stage_ready(sr2), .stage_error(se2), .ready(ready2),
    .rd_stage(rs2), .rd_word(rw2), .rd_data(rd2)
  );

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, expv);
    end
  endtask

  task automatic fill_pattern();
    for (int s = 0; s < NS; s++) begin
      int sum = 0;
      for (int i = 0; i < SW; i++) begin
        rom[s*(SW+1)+i] = 8'((s*37 + i) % 256);
        sum += (s*37 + i) % 256;
      end
      rom[s*(SW+1)+SW] = 8'(sum);
    end
  endtask

  task automatic fill_random(input logic [2:0] bad);
    for (int s = 0; s < NS; s++) begin
      int sum = 0;
      for (int i = 0; i < SW; i++) begin
        rom[s*(SW+1)+i] = 8'($urandom);
        sum += int'(rom[s*(SW+1)+i]);
      end
      if (bad[s]) sum += int'($urandom_range(1, 255));
      rom[s*(SW+1)+SW] = 8'(sum);
    end
  endtask

  task automatic fill2(input bit bad);
    int sum = 0;
    for (int i = 0; i < SW; i++) begin
      rom2[i] = 8'($urandom);
      sum += int'(rom2[i]);
    end
    if (bad) sum += 7;
    rom2[SW] = 8'(sum);
  endtask

  task automatic calc_good();
    for (int s = 0; s < NS; s++) begin
      int sum = 0;
      for (int i = 0; i < SW; i++)
        sum += int'(rom[s*(SW+1)+i]);
      good[s] = (8'(sum) == rom[s*(SW+1)+SW]);
    end
  endtask

  function automatic logic [18:0] exp_obs(input int c);
    logic [2:0] esr, ese;
    logic [9:0] ea;
    esr = '0;
    ese = '0;
    for (int s = 0; s < NS; s++) begin
      if (c >= 1 + (s+1)*(SW+1) + L) begin
        if (good[s]) esr[s] = 1'b1;
        else         ese[s] = 1'b1;
      end
    end
    if (c >= 1 && c <= N)          ea = 10'(c - 1);
    else if (c > N && c <= N + L)  ea = 10'(N - 1);
    else                           ea = 10'd0;
    return {(c >= 1 && c <= N + L), (c == N + L + 1),
            &esr, esr, ese, ea};
  endfunction

  task automatic run_load(input int pulse_at, input int abort_at,
                          input int tail);
    ls = 1'b1;
    for (int c = 1; c <= N + L + 1 + tail; c++) begin
      @(posedge clk);
      @(negedge clk);
      ls = (c == pulse_at);
      check($sformatf("cyc%0d", c),
            64'({busy, done, ready, sr, se, ra}), 64'(exp_obs(c)));
      if (c == abort_at) begin
        rst_n = 1'b0;
        #1;
        check("abort_zero",
              64'({busy, done, ready, sr, se, ra, rd}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
    end
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < SW; w++)
        exp_mem[s][w] = rom[s*(SW+1)+w];
  endtask

  task automatic read_one(input int s, input int w);
    logic [7:0] e;
    rs = 2'(s);
    rw = 8'(w);
    @(posedge clk);
    @(negedge clk);
    e = 8'h00;
    if (s < NS && w < SW) e = exp_mem[s][w];
    check($sformatf("rd s%0d w%0d", s, w), 64'(rd), 64'(e));
  endtask

  task automatic run2(input bit bad);
    int dc = -1;
    ls2 = 1'b1;
    for (int c = 1; c <= 400; c++) begin
      @(posedge clk);
      @(negedge clk);
      ls2 = 1'b0;
      if (done2) begin
        dc = c;
        break;
      end
    end
    check("dut2_done_cycle", 64'(dc), 64'(N2 + L2 + 1));
    check("dut2_flags", 64'({busy2, ready2, sr2, se2}),
          64'({1'b0, !bad, !bad, bad}));
  endtask

  initial begin
    rst_n = 1'b0;
    ls = 1'b0; ls2 = 1'b0;
    rs = '0; rw = '0; rs2 = '0; rw2 = '0;
    for (int i = 0; i < 1024; i++) begin
      rom[i]  = 8'h00;
      rom2[i] = 8'h00;
    end
    repeat (3) @(negedge clk);
    check("reset_dut1", 64'({busy, done, ready, sr, se, ra, rd}), 64'd0);
    check("reset_dut2",
          64'({busy2, done2, ready2, sr2, se2, ra2, rd2}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // clean load with the reference pattern, idle tail
    fill_pattern();
    calc_good();
    run_load(0, 0, 3);
    check("clean_ready", 64'({ready, sr, se}), 64'({1'b1, 3'b111, 3'b000}));

    // full readback plus out-of-range rows/columns
    for (int s = 0; s <= NS; s++)
      for (int w = 0; w <= SW + 1; w++)
        read_one(s, w);
    read_one(1, 255);
    read_one(3, 0);

    // checksum fault on stage 1
    rom[1*(SW+1)+SW] = rom[1*(SW+1)+SW] ^ 8'h5A;
    calc_good();
    run_load(0, 0, 0);
    check("fault_flags", 64'({ready, sr, se}),
          64'({1'b0, 3'b101, 3'b010}));

    // ignored restart mid-load, then back-to-back reload from done cycle
    fill_pattern();
    calc_good();
    run_load(100, 0, 0);
    run_load(0, 0, 2);

    // reset mid-load then clean restart
    fill_random(3'($urandom_range(0, 7)));
    calc_good();
    run_load(0, 300, 0);
    run_load(0, 0, 0);
    for (int k = 0; k < 40; k++)
      read_one(int'($urandom_range(0, NS - 1)),
               int'($urandom_range(0, SW - 1)));

    // randomized contents and fault masks
    for (int r = 0; r < 3; r++) begin
      fill_random(3'($urandom_range(0, 7)));
      calc_good();
      run_load(0, 0, 0);
      for (int k = 0; k < 30; k++)
        read_one(int'($urandom_range(0, NS)),
                 int'($urandom_range(0, 255)));
    end

    // single stage, latency 3
    fill2(1'b0);
    run2(1'b0);
    for (int k = 0; k < 20; k++) begin
      int w = int'($urandom_range(0, SW));
      rs2 = 1'b0;
      rw2 = 8'(w);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("rd2 w%0d", w), 64'(rd2),
            64'(w < SW ? rom2[w] : 8'h00));
    end
    fill2(1'b1);
    run2(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
